// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word over valid/ready
// and emits it one bit per enabled clock, pulsing done after the final bit.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             accept;
  logic             last_bit;

  assign last_bit = (state_q == SHIFT) && (cnt_q == '0) && en;
  assign accept   = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // A load on the edge that consumes the last bit overrides the return to IDLE,
  // so consecutive words stream with no gap.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: ;
      SHIFT: begin
        if (en) begin
          if (cnt_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
            sr_d    = '0;
          end else begin
            sr_d  = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      sr_d    = din;
      cnt_d   = CW'(WIDTH - 1);
      state_d = SHIFT;
    end
  end

  always_comb begin
    load_ready = rst && ((state_q == IDLE) || last_bit);
    sout_valid = (state_q == SHIFT);
    busy       = (state_q == SHIFT);
    sout       = 1'b0;
    if (state_q == SHIFT) sout = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    done       = done_q;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share
// stimulus and are checked each cycle against a word/bit-index reference model.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, en, load_valid;
  logic [W-1:0] din;
  logic         s1, v1, b1, d1, r1;
  logic         s0, v0, b0, d0, r0;

  int total = 0;
  int bad   = 0;

  // Reference model: the word in flight and how many bits have been consumed.
  logic         m_act;
  logic [W-1:0] m_word;
  int           m_idx;
  logic         m_done;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_ready(r1),
    .din(din), .sout(s1), .sout_valid(v1), .busy(b1), .done(d1)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_ready(r0),
    .din(din), .sout(s0), .sout_valid(v0), .busy(b0), .done(d0)
  );

  always #5 clk = ~clk;

  function automatic logic model_ready();
    return rst && (!m_act || (m_idx == W - 1 && en));
  endfunction

  function automatic logic [9:0] model_out();
    logic ms, ls, rd;
    ms = m_act ? m_word[W-1-m_idx] : 1'b0;
    ls = m_act ? m_word[m_idx]     : 1'b0;
    rd = model_ready();
    return {ms, m_act, m_act, m_done, rd, ls, m_act, m_act, m_done, rd};
  endfunction

  // Called right after a posedge while the inputs of that edge are still applied.
  task automatic model_step();
    logic acc, nd;
    acc = load_valid && model_ready();
    if (!rst) begin
      m_act = 1'b0; m_idx = 0; m_done = 1'b0;
    end else begin
      nd = 1'b0;
      if (m_act && en) begin
        m_idx++;
        if (m_idx == W) begin nd = 1'b1; m_act = 1'b0; end
      end
      if (acc) begin m_act = 1'b1; m_word = din; m_idx = 0; end
      m_done = nd;
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic lv, input logic [W-1:0] d);
    rst = r; en = e; load_valid = lv; din = d;
  endtask

  function automatic logic [9:0] observed();
    return {s1, v1, b1, d1, r1, s0, v0, b0, d0, r0};
  endfunction

  task automatic test_reset();
    logic [9:0] exp;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 8'hFF);
      @(negedge clk);
      exp = model_out();
      total++;
      if (observed() !== exp || r1 !== 1'b0) begin
        bad++; $display("FAIL reset cyc=%0d got=%b want=%b", i, observed(), exp);
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_msb_a5();
    logic [9:0] exp;
    logic [W-1:0] got = '0;
    int ndone = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, i == 0, i == 0 ? 8'hA5 : 8'h00);
      @(negedge clk);
      exp = model_out();
      if (v1) got = {got[W-2:0], s1};
      if (d1) ndone++;
      total++;
      if (observed() !== exp) begin
        bad++; $display("FAIL msb_a5 cyc=%0d got=%b want=%b", i, observed(), exp);
      end
      if (i == 9) begin
        total++;
        if (d1 !== 1'b1) begin bad++; $display("FAIL msb_a5_done_cycle9 got=%b want=1", d1); end
      end
      @(posedge clk); model_step(); #1;
    end
    total++;
    if (got !== 8'hA5 || ndone != 1) begin
      bad++; $display("FAIL msb_a5_seq got=%h/%0d want=a5/1", got, ndone);
    end
  endtask

  task automatic test_lsb_1e();
    logic [9:0] exp;
    logic [W-1:0] got = '0;
    int nbusy = 0, ndone = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, i == 0, i == 0 ? 8'h1E : 8'h00);
      @(negedge clk);
      exp = model_out();
      if (v0) got = {got[W-2:0], s0};
      if (b0) nbusy++;
      if (d0) ndone++;
      total++;
      if (observed() !== exp) begin
        bad++; $display("FAIL lsb_1e cyc=%0d got=%b want=%b", i, observed(), exp);
      end
      @(posedge clk); model_step(); #1;
    end
    total++;
    if (got !== 8'h78 || nbusy != 8 || ndone != 1) begin
      bad++; $display("FAIL lsb_1e_seq got=%h/%0d/%0d want=78/8/1", got, nbusy, ndone);
    end
  endtask

  task automatic test_stall();
    logic [9:0] exp;
    logic [15:0] got = '0;
    int nvalid = 0;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, !(i >= 3 && i <= 5), i == 0, i == 0 ? 8'hA5 : 8'h00);
      @(negedge clk);
      exp = model_out();
      if (v1) begin got = {got[14:0], s1}; nvalid++; end
      total++;
      if (observed() !== exp) begin
        bad++; $display("FAIL stall cyc=%0d got=%b want=%b", i, observed(), exp);
      end
      @(posedge clk); model_step(); #1;
    end
    total++;
    if (nvalid != 11 || got[10:0] !== 11'b10111100101) begin
      bad++; $display("FAIL stall_seq got=%b/%0d want=10111100101/11", got[10:0], nvalid);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp;
    logic [15:0] got = '0;
    int nvalid = 0, ndone = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, i <= 8, i == 0 ? 8'hF0 : 8'h0F);
      @(negedge clk);
      exp = model_out();
      if (v1) begin got = {got[14:0], s1}; nvalid++; end
      if (d1) ndone++;
      total++;
      if (observed() !== exp) begin
        bad++; $display("FAIL b2b cyc=%0d got=%b want=%b", i, observed(), exp);
      end
      @(posedge clk); model_step(); #1;
    end
    total++;
    if (got !== 16'hF00F || nvalid != 16 || ndone != 2) begin
      bad++; $display("FAIL b2b_seq got=%h/%0d/%0d want=f00f/16/2", got, nvalid, ndone);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [9:0] exp;
    for (int i = 0; i < 10; i++) begin
      drive(!(i == 4 || i == 5), 1'b1, i == 0 || i == 4 || i == 5, 8'hA5);
      @(negedge clk);
      exp = model_out();
      total++;
      if (observed() !== exp) begin
        bad++; $display("FAIL rst_mid cyc=%0d got=%b want=%b", i, observed(), exp);
      end
      if (i == 5) begin
        total++;
        if ({s1, v1, b1, d1, r1} !== 5'b0) begin
          bad++; $display("FAIL rst_mid_outputs got=%b want=00000", {s1, v1, b1, d1, r1});
        end
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_ignore_busy_load();
    logic [9:0] exp;
    logic [W-1:0] got = '0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, i == 0 || (i >= 2 && i <= 5), i == 0 ? 8'h3C : W'($urandom));
      @(negedge clk);
      exp = model_out();
      if (v1) got = {got[W-2:0], s1};
      total++;
      if (observed() !== exp) begin
        bad++; $display("FAIL busy_load cyc=%0d got=%b want=%b", i, observed(), exp);
      end
      @(posedge clk); model_step(); #1;
    end
    total++;
    if (got !== 8'h3C) begin bad++; $display("FAIL busy_load_seq got=%h want=3c", got); end
  endtask

  task automatic test_random();
    logic [9:0] exp;
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 4) != 0,
            $urandom_range(0, 1) == 1, W'($urandom));
      @(negedge clk);
      exp = model_out();
      total++;
      if (observed() !== exp) begin
        bad++; $display("FAIL random cyc=%0d got=%b want=%b", i, observed(), exp);
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  initial begin
    m_act = 1'b0; m_word = '0; m_idx = 0; m_done = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    @(posedge clk); model_step(); #1;
    test_reset();
    test_msb_a5();
    test_lsb_1e();
    test_stall();
    test_back_to_back();
    test_reset_mid_word();
    test_ignore_busy_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
